// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_t          : scan FSM states (GUARD = all-off gap, SHOW = digit lit)
//   SEG_OFF          : active-low segment pattern with every segment dark
//   NUM_DIGITS_MIN/MAX : legal range for the digit count, checked at elaboration
package seg_pkg;

  typedef enum logic [0:0] {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int NUM_DIGITS_MIN = 2;
  localparam int NUM_DIGITS_MAX = 8;

endpackage

// File: rtl/seven_segs.sv
// 4-bit hex to seven-segment decoder for common-anode displays.
// Ports:
//   hex : nibble to show (0..F)
//   seg : segments g..a, active-low (0 = segment lit)
module seven_segs
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // NOTE: every path through a combinational block must assign its outputs;
  // the default first assignment is what keeps this from inferring a latch.
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit
// seven-segment display. One shared decoder is fed the nibble of the digit
// being visited; each visit is preceded by an all-off guard gap to stop
// ghosting. New display values arrive over a valid/ready port into a
// one-entry pending buffer and are committed only at the end of a frame.
//
// Optional feature: define SEG_LZS_EN for leading-zero suppression
// (digits above the most significant non-zero digit go dark; digit 0 never).
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   wr_valid    : wr_data/wr_blank valid
//   wr_ready    : pending buffer empty, a write can be taken
//   wr_data     : nibble i drives digit i
//   wr_blank    : bit i forces digit i dark
//   seg         : segments g..a, active-low
//   dig_sel     : digit enables, active-low, at most one low
//   frame_tick  : one-cycle pulse after each frame boundary
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_GUARD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_GUARD) ? REFRESH_DIV : BLANK_GUARD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LOAD  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(BLANK_GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be within 2..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("seg_scan_ctrl: REFRESH_DIV must be at least 2");
  end
  if (BLANK_GUARD < 1) begin : g_bad_guard
    $error("seg_scan_ctrl: BLANK_GUARD must be at least 1");
  end

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                cnt;
  logic                         pend_full;
  logic [NUM_DIGITS-1:0][3:0]   pend_data;
  logic [NUM_DIGITS-1:0]        pend_blank;
  logic [NUM_DIGITS-1:0][3:0]   disp_data;
  logic [NUM_DIGITS-1:0]        disp_blank;
  logic [NUM_DIGITS-1:0]        eff_blank;
  logic [3:0]                   cur_nibble;
  logic [6:0]                   dec_seg;
  logic                         last_cycle;
  logic                         commit;
  logic                         xfer;

  // cnt holds the cycles left in the current state after this one, so the
  // state ends when it reaches zero.
  assign last_cycle = (cnt == '0);
  assign commit     = (state == SHOW) && last_cycle && (idx == IDX_LAST);
  assign wr_ready   = ~pend_full;
  assign xfer       = wr_valid && !pend_full;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        GUARD: begin
          if (last_cycle) begin
            state <= SHOW;
            cnt   <= SHOW_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHOW: begin
          if (last_cycle) begin
            state <= GUARD;
            cnt   <= GUARD_LOAD;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // The commit reads pending before a same-cycle write overwrites it; a write
  // cannot land while pending is full, so a write on the commit edge only
  // happens with pending empty and simply waits for the next frame.
  // NOTE: the display registers are data storage yet are reset on purpose:
  // the display must come up dark, not showing power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_blank <= '0;
      disp_data  <= '0;
      disp_blank <= '1;
    end else begin
      if (commit && pend_full) begin
        disp_data  <= pend_data;
        disp_blank <= pend_blank;
        pend_full  <= 1'b0;
      end
      if (xfer) begin
        pend_data  <= wr_data;
        pend_blank <= wr_blank;
        pend_full  <= 1'b1;
      end
    end
  end

`ifdef SEG_LZS_EN
  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin : p_eff_blank
    logic upper_zero;
    eff_blank  = disp_blank;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (disp_data[i] == 4'h0);
      eff_blank[i] = disp_blank[i] | upper_zero;
    end
  end
`else
  assign eff_blank = disp_blank;
`endif

  // Shared decoder: the idx mux in front of it is the only path to seg.
  assign cur_nibble = disp_data[idx];

  seven_segs u_dec (
    .hex (cur_nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dig_sel    <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= commit;
      if (state == SHOW) begin
        dig_sel <= ~(NUM_DIGITS'(1) << idx);
        seg     <= eff_blank[idx] ? SEG_OFF : dec_seg;
      end else begin
        dig_sel <= '1;
        seg     <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_GUARD=2, 24-cycle frame). Accepted writes are pushed to a queue; at
// each frame boundary the frame model takes the oldest write accepted before
// the commit edge, and every cycle of the following frame is compared
// against the digit/segment pattern that frame should show.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 2;
  localparam int FRAME = N * (G + R);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [15:0]  wr_data = '0;
  logic [3:0]   wr_blank = '0;
  logic [6:0]   seg;
  logic [3:0]   dig_sel;
  logic         frame_tick;

  seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_GUARD (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_blank   (wr_blank),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
    int unsigned acc;
  } wr_t;

  wr_t         pend_q[$];
  logic [15:0] cur_data  = '0;
  logic [3:0]  cur_blank = 4'hF;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] d, input logic [3:0] b, input int i);
    logic [3:0] nib;
    logic       dark;
    nib  = d[i*4 +: 4];
    dark = b[i];
`ifdef SEG_LZS_EN
    if (i != 0 && (d >> (i * 4)) == 16'h0) dark = 1'b1;
`endif
    return dark ? 7'h7F : hex_seg(nib);
  endfunction

  // Checks one frame sample-by-sample. Sample j=1 is the negedge right after
  // the previous frame_tick (or right at reset release); sample j=FRAME is the
  // negedge carrying this frame's frame_tick.
  task automatic check_frame(input int f, input bit first);
    for (int j = 1; j <= FRAME; j++) begin
      logic [3:0] exp_sel;
      logic [6:0] exp_sg;
      int         d;
      if (!(first && j == 1)) @(negedge clk);
      exp_sel = 4'hF;
      exp_sg  = 7'h7F;
      if (j >= 3 && ((j - 3) % (G + R)) < R) begin
        d       = (j - 3) / (G + R);
        exp_sel = ~(4'b1 << d);
        exp_sg  = exp_seg(cur_data, cur_blank, d);
      end
      check($sformatf("f%0d_j%0d_dig_sel", f, j), dig_sel, exp_sel);
      check($sformatf("f%0d_j%0d_seg", f, j), seg, exp_sg);
      check($sformatf("f%0d_j%0d_frame_tick", f, j), frame_tick, (j == FRAME));
    end
    // Commit edge is the posedge just before this sample.
    if (pend_q.size() > 0 && pend_q[0].acc < cyc) begin
      wr_t w;
      w         = pend_q.pop_front();
      cur_data  = w.data;
      cur_blank = w.blank;
    end
  endtask

  // Called at a negedge. Holds wr_valid until wr_ready is seen, records the
  // edge on which the transfer happens and whether frame_tick was high then.
  task automatic do_write(input logic [15:0] d, input logic [3:0] b,
                          output int unsigned acc, output logic tk);
    int waited;
    waited   = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_blank = b;
    while (wr_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (wr_ready !== 1'b1) begin
      check("write_timeout", wr_ready, 1'b1);
      acc = 0;
      tk  = 1'b0;
      wr_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    tk  = frame_tick;
    pend_q.push_back('{data: d, blank: b, acc: acc});
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    check(tag, frame_tick, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    logic        tk;
    int          n;

    repeat (2) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_dig_sel", dig_sel, 4'hF);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_frame_tick", frame_tick, 1'b0);
    rst_n = 1'b1;

    fork
      begin : monitor
        check_frame(1, 1'b1);
        for (int f = 2; f <= 7; f++) check_frame(f, 1'b0);
      end
      begin : driver
        repeat (4) @(negedge clk);
        do_write(16'h1A2F, 4'h0, a, tk);          // shown in frame 2
        wait_tick("sync_tick1");
        do_write(16'h8888, 4'b1000, a, tk);       // shown in frame 3
        check("ready_drop", wr_ready, 1'b0);
        do_write(16'hB6D4, 4'h0, a, tk);          // blocked until the commit
        check("ready_after_commit", tk, 1'b1);
        wait_tick("sync_tick3");
        repeat (FRAME - 1) @(negedge clk);
        do_write(16'h0050, 4'h0, a, tk);          // lands on the commit edge
        check("accept_before_tick", tk, 1'b0);
        check("tick_on_accept_edge", frame_tick, 1'b1);
        wait_tick("sync_tick5");
        do_write(16'h0000, 4'h0, a, tk);          // shown in frame 7
      end
    join

    // Asynchronous reset in the middle of a lit digit.
    n = 0;
    while (dig_sel === 4'hF && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("lit_before_reset", (dig_sel !== 4'hF), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_dig_sel", dig_sel, 4'hF);
    check("async_rst_wr_ready", wr_ready, 1'b1);
    check("async_rst_frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_dig_sel", dig_sel, 4'hE);
    check("post_rst_seg_dark", seg, 7'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
